// File: rtl/lsu_mem_stage_if.sv
// Signal bundle for the memory-access stage: execute handshake, writeback
// handshake and the req/ack data bus. The master modport is the stage itself,
// the slave modport is the surrounding pipeline and memory.
interface lsu_mem_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // execute -> stage
    logic                    Evalid;
    logic                    Mready;
    logic [DATA_WIDTH-1:0]   ALUResult;
    logic [DATA_WIDTH-1:0]   StoreData;
    logic                    MemRead;
    logic                    MemWrite;
    logic [2:0]              MemFunct3;
    // stage -> writeback
    logic                    Mvalid;
    logic                    Wready;
    logic [DATA_WIDTH-1:0]   MemResult;
    logic                    MemErr;
    // data bus
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [3:0]              mem_wstrb;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    modport master (
        input  Evalid, ALUResult, StoreData, MemRead, MemWrite, MemFunct3,
        input  Wready, mem_rdata, mem_ack,
        output Mready, Mvalid, MemResult, MemErr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output Evalid, ALUResult, StoreData, MemRead, MemWrite, MemFunct3,
        output Wready, mem_rdata, mem_ack,
        input  Mready, Mvalid, MemResult, MemErr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: takes one ALU result at a time, performs at most one
// load or store on the req/ack bus, and hands the result to writeback.
// Byte lanes are fixed at four 8-bit lanes, so DATA_WIDTH is expected to be 32.
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_mem_stage_if.master      bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // Last BUS cycle before the access is abandoned (counter reaches TIMEOUT).
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    mready_r;
    logic                    mvalid_r;
    logic [DATA_WIDTH-1:0]   mem_result_r;
    logic                    mem_err_r;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [DATA_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [3:0]              mem_wstrb_r;
    logic [CW-1:0]           cnt_r;
    logic [DATA_WIDTH-1:0]   alu_r;
    logic [2:0]              funct3_r;

    logic                    req_err_s;
    logic [3:0]              wstrb_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic [7:0]              byte_s;
    logic [15:0]             half_s;
    logic [DATA_WIDTH-1:0]   load_s;

    // Classify the incoming transaction: conflicting op, illegal size or misalignment.
    always_comb begin
        logic illegal_s;
        logic misalign_s;
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        case (bus.MemFunct3)
            3'b000, 3'b100: illegal_s = bus.MemWrite & bus.MemFunct3[2];
            3'b001, 3'b101: begin
                illegal_s  = bus.MemWrite & bus.MemFunct3[2];
                misalign_s = bus.ALUResult[0];
            end
            3'b010:  misalign_s = (bus.ALUResult[1:0] != 2'b00);
            default: illegal_s = 1'b1;
        endcase
        if (bus.MemRead & bus.MemWrite) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = illegal_s | misalign_s;
        end
    end

    // Store lane placement: replicate the source across lanes and enable the target bytes.
    always_comb begin
        wstrb_s = 4'b0000;
        wdata_s = {DATA_WIDTH{1'b0}};
        case (bus.MemFunct3[1:0])
            2'b00: begin
                wstrb_s = 4'b0001 << bus.ALUResult[1:0];
                wdata_s = {4{bus.StoreData[7:0]}};
            end
            2'b01: begin
                if (bus.ALUResult[1]) begin
                    wstrb_s = 4'b1100;
                end else begin
                    wstrb_s = 4'b0011;
                end
                wdata_s = {2{bus.StoreData[15:0]}};
            end
            2'b10: begin
                wstrb_s = 4'b1111;
                wdata_s = bus.StoreData;
            end
            default: begin
                wstrb_s = 4'b0000;
                wdata_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Load lane selection by the captured address, then sign or zero extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        load_s = {DATA_WIDTH{1'b0}};
        case (alu_r[1:0])
            2'b00:   byte_s = bus.mem_rdata[7:0];
            2'b01:   byte_s = bus.mem_rdata[15:8];
            2'b10:   byte_s = bus.mem_rdata[23:16];
            2'b11:   byte_s = bus.mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (alu_r[1]) begin
            half_s = bus.mem_rdata[31:16];
        end else begin
            half_s = bus.mem_rdata[15:0];
        end
        case (funct3_r)
            3'b000:  load_s = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            3'b001:  load_s = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            3'b010:  load_s = bus.mem_rdata;
            3'b100:  load_s = {{(DATA_WIDTH-8){1'b0}}, byte_s};
            3'b101:  load_s = {{(DATA_WIDTH-16){1'b0}}, half_s};
            default: load_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Transaction FSM with all stage and bus outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            mready_r     <= 1'b1;
            mvalid_r     <= 1'b0;
            mem_result_r <= {DATA_WIDTH{1'b0}};
            mem_err_r    <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {DATA_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            mem_wstrb_r  <= 4'b0000;
            cnt_r        <= {CW{1'b0}};
            alu_r        <= {DATA_WIDTH{1'b0}};
            funct3_r     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Evalid) begin
                        alu_r    <= bus.ALUResult;
                        funct3_r <= bus.MemFunct3;
                        mready_r <= 1'b0;
                        if (!bus.MemRead && !bus.MemWrite) begin
                            mem_result_r <= bus.ALUResult;
                            mem_err_r    <= 1'b0;
                            mvalid_r     <= 1'b1;
                            state_r      <= RESP;
                        end else if (req_err_s) begin
                            mem_result_r <= bus.ALUResult;
                            mem_err_r    <= 1'b1;
                            mvalid_r     <= 1'b1;
                            state_r      <= RESP;
                        end else begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= bus.MemWrite;
                            mem_addr_r  <= {bus.ALUResult[DATA_WIDTH-1:2], 2'b00};
                            // Reads drive no strobes and no write data.
                            mem_wdata_r <= bus.MemWrite ? wdata_s : {DATA_WIDTH{1'b0}};
                            mem_wstrb_r <= bus.MemWrite ? wstrb_s : 4'b0000;
                            cnt_r       <= {CW{1'b0}};
                            state_r     <= BUS;
                        end
                    end
                end
                BUS: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus.mem_ack) begin
                        mem_req_r    <= 1'b0;
                        mem_err_r    <= 1'b0;
                        mvalid_r     <= 1'b1;
                        mem_result_r <= mem_we_r ? alu_r : load_s;
                        state_r      <= RESP;
                    end else if (cnt_r == TO_LAST) begin
                        mem_req_r    <= 1'b0;
                        mem_err_r    <= 1'b1;
                        mvalid_r     <= 1'b1;
                        mem_result_r <= {DATA_WIDTH{1'b0}};
                        state_r      <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    // Mvalid is always high here, so Wready alone completes the handoff.
                    if (bus.Wready) begin
                        mvalid_r  <= 1'b0;
                        mem_err_r <= 1'b0;
                        mready_r  <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mready_r  <= 1'b1;
                    mvalid_r  <= 1'b0;
                    mem_err_r <= 1'b0;
                    mem_req_r <= 1'b0;
                    cnt_r     <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.Mready    = mready_r;
    assign bus.Mvalid    = mvalid_r;
    assign bus.MemResult = mem_result_r;
    assign bus.MemErr    = mem_err_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage (TIMEOUT shortened to 4).
module tb_lsu_mem_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    lsu_mem_stage_if #(.DATA_WIDTH(32)) bus_if ();

    lsu_mem_stage #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction for a single cycle while the stage is idle.
    task automatic issue(input logic [31:0] alu, input logic [31:0] sd,
                         input logic rd, input logic wr, input logic [2:0] f3);
        bus_if.ALUResult = alu;
        bus_if.StoreData = sd;
        bus_if.MemRead   = rd;
        bus_if.MemWrite  = wr;
        bus_if.MemFunct3 = f3;
        bus_if.Evalid    = 1'b1;
        tick();
        bus_if.Evalid    = 1'b0;
        bus_if.MemRead   = 1'b0;
        bus_if.MemWrite  = 1'b0;
    endtask

    // Return mem_ack so that it is sampled in the n-th BUS cycle.
    task automatic ack_after(input int n, input logic [31:0] rdata);
        for (int i = 1; i < n; i++) tick();
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = rdata;
        tick();
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'h0;
    endtask

    task automatic release_wb();
        bus_if.Wready = 1'b1;
        tick();
        bus_if.Wready = 1'b0;
        check_val("ready_after_wb", {31'd0, bus_if.Mready}, 32'd1);
        check_val("valid_after_wb", {31'd0, bus_if.Mvalid}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus_if.Evalid = 1'b0; bus_if.ALUResult = 32'h0; bus_if.StoreData = 32'h0;
        bus_if.MemRead = 1'b0; bus_if.MemWrite = 1'b0; bus_if.MemFunct3 = 3'b000;
        bus_if.Wready = 1'b0; bus_if.mem_rdata = 32'h0; bus_if.mem_ack = 1'b0;
        repeat (2) tick();
        check_val("rst_mready",  {31'd0, bus_if.Mready}, 32'd1);
        check_val("rst_mvalid",  {31'd0, bus_if.Mvalid}, 32'd0);
        check_val("rst_result",  bus_if.MemResult, 32'h0);
        check_val("rst_err",     {31'd0, bus_if.MemErr}, 32'd0);
        check_val("rst_req",     {31'd0, bus_if.mem_req}, 32'd0);
        check_val("rst_addr",    bus_if.mem_addr, 32'h0);
        check_val("rst_wstrb",   {28'd0, bus_if.mem_wstrb}, 32'd0);
        rst = 1'b0;
        tick();

        // Non-memory op: result one cycle later, no bus activity.
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 3'b010);
        check_val("nm_valid",  {31'd0, bus_if.Mvalid}, 32'd1);
        check_val("nm_result", bus_if.MemResult, 32'h1234);
        check_val("nm_err",    {31'd0, bus_if.MemErr}, 32'd0);
        check_val("nm_req",    {31'd0, bus_if.mem_req}, 32'd0);
        check_val("nm_mready", {31'd0, bus_if.Mready}, 32'd0);
        release_wb();

        // lb at 0x80000003, ack 3 cycles after request.
        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b000);
        check_val("lb_req",   {31'd0, bus_if.mem_req}, 32'd1);
        check_val("lb_addr",  bus_if.mem_addr, 32'h8000_0000);
        check_val("lb_we",    {31'd0, bus_if.mem_we}, 32'd0);
        check_val("lb_wstrb", {28'd0, bus_if.mem_wstrb}, 32'd0);
        ack_after(3, 32'h80FF_0011);
        check_val("lb_req_drop", {31'd0, bus_if.mem_req}, 32'd0);
        check_val("lb_valid",    {31'd0, bus_if.Mvalid}, 32'd1);
        check_val("lb_result",   bus_if.MemResult, 32'hFFFF_FF80);
        check_val("lb_err",      {31'd0, bus_if.MemErr}, 32'd0);
        release_wb();

        // Same access as lbu.
        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'b100);
        ack_after(3, 32'h80FF_0011);
        check_val("lbu_result", bus_if.MemResult, 32'h0000_0080);
        release_wb();

        // lh on the upper half, sign extended.
        issue(32'h0000_0106, 32'h0, 1'b1, 1'b0, 3'b001);
        check_val("lh_addr", bus_if.mem_addr, 32'h0000_0104);
        ack_after(1, 32'h8001_1234);
        check_val("lh_result", bus_if.MemResult, 32'hFFFF_8001);
        release_wb();

        // sh at 0x100.
        issue(32'h0000_0100, 32'hABCD_1234, 1'b0, 1'b1, 3'b001);
        check_val("sh0_we",    {31'd0, bus_if.mem_we}, 32'd1);
        check_val("sh0_wdata", bus_if.mem_wdata, 32'h1234_1234);
        check_val("sh0_wstrb", {28'd0, bus_if.mem_wstrb}, 32'h3);
        ack_after(1, 32'h0);
        check_val("sh0_result", bus_if.MemResult, 32'h0000_0100);
        check_val("sh0_err",    {31'd0, bus_if.MemErr}, 32'd0);
        release_wb();

        // sh at 0x102.
        issue(32'h0000_0102, 32'hABCD_1234, 1'b0, 1'b1, 3'b001);
        check_val("sh2_wstrb", {28'd0, bus_if.mem_wstrb}, 32'hC);
        check_val("sh2_addr",  bus_if.mem_addr, 32'h0000_0100);
        ack_after(2, 32'h0);
        check_val("sh2_result", bus_if.MemResult, 32'h0000_0102);
        release_wb();

        // sb at 0x101.
        issue(32'h0000_0101, 32'h0000_005A, 1'b0, 1'b1, 3'b000);
        check_val("sb_wstrb", {28'd0, bus_if.mem_wstrb}, 32'h2);
        check_val("sb_wdata", bus_if.mem_wdata, 32'h5A5A_5A5A);
        ack_after(1, 32'h0);
        release_wb();

        // Misaligned lw.
        issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b010);
        check_val("mis_err",    {31'd0, bus_if.MemErr}, 32'd1);
        check_val("mis_result", bus_if.MemResult, 32'h0000_0102);
        check_val("mis_req",    {31'd0, bus_if.mem_req}, 32'd0);
        check_val("mis_valid",  {31'd0, bus_if.Mvalid}, 32'd1);
        release_wb();
        check_val("mis_err_clr", {31'd0, bus_if.MemErr}, 32'd0);

        // Read and write both set.
        issue(32'h0000_0200, 32'h0, 1'b1, 1'b1, 3'b010);
        check_val("rw_err", {31'd0, bus_if.MemErr}, 32'd1);
        check_val("rw_req", {31'd0, bus_if.mem_req}, 32'd0);
        release_wb();

        // Store with an unsigned size code is illegal.
        issue(32'h0000_0000, 32'h0, 1'b0, 1'b1, 3'b100);
        check_val("ill_err", {31'd0, bus_if.MemErr}, 32'd1);
        check_val("ill_req", {31'd0, bus_if.mem_req}, 32'd0);
        release_wb();

        // Timeout: no ack for 4 BUS cycles.
        issue(32'h0000_0040, 32'h0, 1'b1, 1'b0, 3'b010);
        check_val("to_req_on", {31'd0, bus_if.mem_req}, 32'd1);
        repeat (3) tick();
        check_val("to_req_held", {31'd0, bus_if.mem_req}, 32'd1);
        check_val("to_not_yet",  {31'd0, bus_if.Mvalid}, 32'd0);
        tick();
        check_val("to_req_drop", {31'd0, bus_if.mem_req}, 32'd0);
        check_val("to_valid",    {31'd0, bus_if.Mvalid}, 32'd1);
        check_val("to_err",      {31'd0, bus_if.MemErr}, 32'd1);
        check_val("to_result",   bus_if.MemResult, 32'h0);
        release_wb();

        // Ack on the 4th BUS cycle wins over the timeout.
        issue(32'h0000_0044, 32'h0, 1'b1, 1'b0, 3'b010);
        ack_after(4, 32'hDEAD_BEEF);
        check_val("late_ack_err",    {31'd0, bus_if.MemErr}, 32'd0);
        check_val("late_ack_result", bus_if.MemResult, 32'hDEAD_BEEF);
        check_val("late_ack_valid",  {31'd0, bus_if.Mvalid}, 32'd1);
        release_wb();

        // Backpressure with a competing Evalid held high.
        issue(32'h0000_55AA, 32'h0, 1'b0, 1'b0, 3'b010);
        bus_if.ALUResult = 32'h0000_0300;
        bus_if.MemRead   = 1'b1;
        bus_if.MemFunct3 = 3'b010;
        bus_if.Evalid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid",  {31'd0, bus_if.Mvalid}, 32'd1);
            check_val("bp_result", bus_if.MemResult, 32'h0000_55AA);
            check_val("bp_mready", {31'd0, bus_if.Mready}, 32'd0);
        end
        bus_if.Wready = 1'b1;
        tick();
        bus_if.Wready = 1'b0;
        bus_if.Evalid = 1'b0;
        bus_if.MemRead = 1'b0;
        check_val("bp_rel_mready", {31'd0, bus_if.Mready}, 32'd1);
        check_val("bp_rel_valid",  {31'd0, bus_if.Mvalid}, 32'd0);
        tick();
        check_val("bp_no_accept_req",   {31'd0, bus_if.mem_req}, 32'd0);
        check_val("bp_no_accept_ready", {31'd0, bus_if.Mready}, 32'd1);

        // Reset in the middle of a bus access.
        issue(32'h0000_0080, 32'h0, 1'b1, 1'b0, 3'b010);
        check_val("rb_req_on", {31'd0, bus_if.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rb_req",    {31'd0, bus_if.mem_req}, 32'd0);
        check_val("rb_mready", {31'd0, bus_if.Mready}, 32'd1);
        check_val("rb_addr",   bus_if.mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h1111_2222;
        tick();
        bus_if.mem_ack   = 1'b0;
        tick();
        check_val("rb_no_valid", {31'd0, bus_if.Mvalid}, 32'd0);
        check_val("rb_ready",    {31'd0, bus_if.Mready}, 32'd1);
        check_val("rb_result",   bus_if.MemResult, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Accepts the ALU result (the effective address, or the pass-through result for non-memory ops) over a valid/ready handshake and performs at most one load or store on a simple req/ack data bus.
- Presents the stage result to writeback over a second valid/ready handshake.
- Carries one transaction at a time, with no bypass.

Parameters:
- DATA_WIDTH, 32, width of the address, data and result paths (byte lanes fixed at 4).
- TIMEOUT, 255, number of BUS-state cycles without mem_ack before the access is aborted with an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Evalid  in  1  execute result valid.
- Mready  out  1  stage can accept a new transaction.
- ALUResult  in  DATA_WIDTH  effective address, or result for non-memory ops.
- StoreData  in  DATA_WIDTH  store source (rs2).
- MemRead  in  1  transaction is a load.
- MemWrite  in  1  transaction is a store.
- MemFunct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- Mvalid  out  1  MemResult/MemErr valid to writeback.
- Wready  in  1  writeback accepts.
- MemResult  out  DATA_WIDTH  load data (extended), or ALUResult.
- MemErr  out  1  misaligned, illegal or timed-out access.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_WIDTH  word-aligned address ({addr[31:2], 2'b00}).
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0 for reads.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state, including mid-bus-access):
  - state=IDLE, Mready=1, Mvalid=0, MemResult=0, MemErr=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, timeout counter=0.
  - An in-flight bus access is abandoned; a late mem_ack is ignored.
- Registers: all outputs registered. FSM states IDLE, BUS, RESP.
- IDLE (Mready=1), on Evalid:
  - Capture ALUResult, StoreData, MemRead, MemWrite, MemFunct3. Next cycle Mready=0.
  - Non-memory (MemRead=MemWrite=0): MemResult=ALUResult, Mvalid=1, go RESP. Latency 1 cycle.
  - Error, no bus access: MemRead&MemWrite both set, illegal funct3 (store with funct3[2]=1, or 011/110/111), or misalignment (h/hu with addr[0]=1, w with addr[1:0]!=0). Result: MemErr=1, MemResult=ALUResult, Mvalid=1, go RESP.
  - Legal access: mem_req=1, mem_we=MemWrite, mem_addr word-aligned, go BUS.
  - Store strobes: sb gives wstrb=1<<addr[1:0] with the byte replicated x4; sh gives 0011 or 1100 with the half replicated x2; sw gives 1111.
- BUS:
  - mem_req and the request fields held stable until mem_ack is sampled high. The counter increments each BUS cycle.
  - On mem_ack: mem_req=0, Mvalid=1, go RESP.
  - Load result: select the lane by addr[1:0], then sign-extend (b/h) or zero-extend (bu/hu).
  - Store result: MemResult=ALUResult.
  - If the counter reaches TIMEOUT with no ack: mem_req=0, MemErr=1, MemResult=0, Mvalid=1, go RESP.
  - mem_ack in the same cycle the counter reaches TIMEOUT: the ack wins and the access completes normally.
- RESP:
  - Mvalid, MemResult and MemErr held stable until Wready.
  - On Mvalid&Wready: Mvalid=0, MemErr=0, Mready=1, counter=0, go IDLE.
  - Evalid in that cycle is not accepted (Mready was 0). Minimum initiation interval is 2 cycles.
- mem_ack outside BUS: ignored, no state change.
- Evalid while Mready=0: ignored; upstream holds it.
- Wready while Mvalid=0: no effect.

Test Plan:
- Non-memory op: Evalid with ALUResult=0x1234, MemRead=MemWrite=0, Wready=1 → Mvalid=1 one cycle later, MemResult=0x1234, MemErr=0, mem_req never asserted.
- lb at 0x80000003, mem_rdata=0x80FF0011, ack 3 cycles after req → mem_addr=0x80000000, mem_wstrb=0, MemResult=0xFFFFFF80.
- Same access as lbu → MemResult=0x00000080.
- sh at 0x100, StoreData=0xABCD1234 → mem_we=1, mem_wdata=0x12341234, mem_wstrb=0011, MemResult=0x100.
- sh at 0x102 → mem_wstrb=1100.
- lw at 0x102 → MemErr=1, MemResult=0x102, no mem_req.
- MemRead&MemWrite both set → MemErr=1, no mem_req.
- No ack, TIMEOUT=4 → mem_req drops after 4 BUS cycles, MemErr=1, MemResult=0.
- Ack on the 4th cycle → normal completion, MemErr=0.
- Backpressure: hold Wready=0 for 5 cycles → Mvalid/MemResult stable, Mready=0, a new Evalid is not accepted.
- Release Wready → Mready=1 the next cycle.
- Assert rst while in BUS → mem_req=0 and Mready=1 immediately; a later mem_ack produces no Mvalid.
